// File: rtl/multiplier_arbiter_taint.sv
// Round-robin sequencer sharing one sequential multiplier among NREQ clients,
// with 1-bit taint carried on every control decision and on the returned product.
module multiplier_arbiter_taint #(
  parameter int WIDTH   = 2048,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4*WIDTH+8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_t,
  input  logic [NREQ*WIDTH-1:0]   op_a,
  input  logic [NREQ*WIDTH-1:0]   op_b,
  input  logic [NREQ-1:0]         op_t,
  output logic [NREQ-1:0]         gnt,
  output logic                    gnt_t,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         done_t,
  output logic                    err,
  output logic [2*WIDTH-1:0]      result,
  output logic                    result_t,
  output logic                    mul_start,
  output logic                    mul_start_t,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  output logic                    mul_op_t,
  input  logic                    mul_done,
  input  logic                    mul_done_t,
  input  logic [2*WIDTH-1:0]      mul_product,
  input  logic                    mul_product_t
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   scan;
  logic            any_req;
  logic [TW-1:0]   timer;
  logic            ctl_t;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (v == PW'(NREQ-1)) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin scan starting at rr_ptr; first set request wins.
  always_comb begin
    pick    = rr_ptr;
    any_req = 1'b0;
    scan    = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_req && req[scan]) begin
        pick    = scan;
        any_req = 1'b1;
      end
      scan = wrap_inc(scan);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      timer     <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      result    <= '0;
      result_t  <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_op_t  <= 1'b0;
      ctl_t     <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      done      <= '0;
      case (state)
        IDLE: begin
          ctl_t <= |req_t;
          if (any_req) begin
            owner     <= pick;
            gnt       <= onehot(pick);
            mul_a     <= op_a[int'(pick)*WIDTH +: WIDTH];
            mul_b     <= op_b[int'(pick)*WIDTH +: WIDTH];
            mul_op_t  <= op_t[pick];
            mul_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Exit timing depends on mul_done, so its taint sticks to control.
          ctl_t <= ctl_t | mul_done_t;
          if (mul_done) begin
            result   <= mul_product;
            err      <= 1'b0;
            result_t <= ctl_t | mul_op_t | mul_product_t;
            done     <= onehot(owner);
            state    <= RESP;
          end else if (timer == TW'(TIMEOUT-1)) begin
            result   <= '0;
            err      <= 1'b1;
            result_t <= ctl_t | mul_op_t;
            done     <= onehot(owner);
            state    <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          rr_ptr <= wrap_inc(owner);
          gnt    <= '0;
          ctl_t  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Which done bit pulses reveals the arbitration, so every bit carries ctl_t.
  assign gnt_t       = ctl_t;
  assign mul_start_t = ctl_t;
  assign done_t      = {NREQ{ctl_t}};

endmodule

// File: tb/tb_multiplier_arbiter_taint.sv
// Scoreboard bench for multiplier_arbiter_taint with a fixed-latency multiplier model.
module tb_multiplier_arbiter_taint;

  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 4*WIDTH+8;
  localparam int MUL_LAT = 19;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0]       req   = '0;
  logic [NREQ-1:0]       req_t = '0;
  logic [NREQ-1:0]       op_t  = '0;
  logic [NREQ*WIDTH-1:0] op_a  = '0;
  logic [NREQ*WIDTH-1:0] op_b  = '0;
  logic [NREQ-1:0]       gnt, done, done_t;
  logic                  gnt_t, err, result_t, mul_start, mul_start_t, mul_op_t;
  logic [2*WIDTH-1:0]    result;
  logic [WIDTH-1:0]      mul_a, mul_b;
  logic                  mul_done;
  logic                  mul_done_t    = 1'b0;
  logic [2*WIDTH-1:0]    mul_product;
  logic                  mul_product_t = 1'b0;

  logic                  mdl_done = 1'b0;
  logic [2*WIDTH-1:0]    mdl_prod = '0;
  int                    mdl_cnt  = 0;
  logic                  hang     = 1'b0;
  logic                  inj_done = 1'b0;
  logic [2*WIDTH-1:0]    inj_prod = '0;

  assign mul_done    = mdl_done | inj_done;
  assign mul_product = inj_done ? inj_prod : mdl_prod;

  multiplier_arbiter_taint #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_t(req_t), .op_a(op_a), .op_b(op_b), .op_t(op_t),
    .gnt(gnt), .gnt_t(gnt_t), .done(done), .done_t(done_t), .err(err),
    .result(result), .result_t(result_t), .mul_start(mul_start), .mul_start_t(mul_start_t),
    .mul_a(mul_a), .mul_b(mul_b), .mul_op_t(mul_op_t), .mul_done(mul_done),
    .mul_done_t(mul_done_t), .mul_product(mul_product), .mul_product_t(mul_product_t)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 owner;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               ctl;
    logic               opt;
    logic               tmo;
    logic               rest;
    logic [2*WIDTH-1:0] prod;
  } job_t;

  job_t q[$];
  job_t mon_e;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   jobs_done = 0;
  int   cyc       = 0;
  int   start_cyc = 0;
  int   md_cyc    = -1;
  logic active     = 1'b0;
  logic prev_start = 1'b0;
  logic [NREQ-1:0] prev_done = '0;
  logic [NREQ-1:0] prev_gnt  = '0;
  logic [NREQ-1:0] exp_oh;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic job_t mk(input int c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [NREQ-1:0] rtv, input logic ot, input logic tmo);
    job_t e;
    e.owner = c;
    e.a     = a;
    e.b     = b;
    e.ctl   = |rtv;
    e.opt   = ot;
    e.tmo   = tmo;
    e.rest  = (|rtv) | ot;
    e.prod  = tmo ? '0 : 16'(a) * 16'(b);
    return e;
  endfunction

  // Multiplier model: product appears MUL_LAT cycles after the start is sampled.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      mdl_cnt  <= 0;
      mdl_done <= 1'b0;
    end else begin
      mdl_done <= 1'b0;
      if (mul_start && !hang) begin
        mdl_cnt  <= MUL_LAT;
        mdl_prod <= 16'(mul_a) * 16'(mul_b);
      end else if (mdl_cnt != 0) begin
        mdl_cnt <= mdl_cnt - 1;
        if (mdl_cnt == 1) mdl_done <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (prev_start) check_eq("start_pulse", mul_start, 0);
      if (prev_done != 0) check_eq("done_pulse", done, 0);
      if (mul_start) begin
        if (q.size() == 0) begin
          check_eq("start_unexp", mul_start, 0);
        end else begin
          exp_oh = 4'b0001 << q[0].owner;
          check_eq("gnt", gnt, exp_oh);
          check_eq("no_overlap", prev_gnt, 0);
          check_eq("mul_a", mul_a, q[0].a);
          check_eq("mul_b", mul_b, q[0].b);
          check_eq("mul_op_t", mul_op_t, q[0].opt);
          check_eq("gnt_t", gnt_t, q[0].ctl);
          check_eq("mul_start_t", mul_start_t, q[0].ctl);
        end
        start_cyc = cyc;
        active    = 1'b1;
        md_cyc    = -1;
      end
      if (mul_done && active && md_cyc < 0) md_cyc = cyc;
      if (done != 0) begin
        jobs_done++;
        if (q.size() == 0) begin
          check_eq("done_unexp", done, 0);
        end else begin
          mon_e  = q.pop_front();
          exp_oh = 4'b0001 << mon_e.owner;
          check_eq("done", done, exp_oh);
          check_eq("gnt_at_done", gnt, exp_oh);
          check_eq("err", err, mon_e.tmo);
          check_eq("result", result, mon_e.prod);
          check_eq("result_t", result_t, mon_e.rest);
          check_eq("done_t", done_t, {NREQ{mon_e.ctl}});
          check_eq("latency", cyc, mon_e.tmo ? start_cyc + TIMEOUT + 1 : md_cyc + 1);
        end
        active = 1'b0;
      end
      prev_start = mul_start;
      prev_done  = done;
      prev_gnt   = gnt;
    end else begin
      active     = 1'b0;
      prev_start = 1'b0;
      prev_done  = '0;
      prev_gnt   = '0;
    end
  end

  task automatic wait_gnt();
    int n = 0;
    while (gnt == '0 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("gnt_seen", gnt != '0, 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (jobs_done < target && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("done_seen", jobs_done, target);
  endtask

  task automatic do_job(input int c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [NREQ-1:0] rtv, input logic ot, input logic tmo);
    int base;
    base = jobs_done;
    op_a[c*WIDTH +: WIDTH] = a;
    op_b[c*WIDTH +: WIDTH] = b;
    op_t[c] = ot;
    q.push_back(mk(c, a, b, rtv, ot, tmo));
    req_t  = rtv;
    req[c] = 1'b1;
    wait_gnt();
    req   = '0;
    req_t = '0;
    op_t  = '0;
    wait_done(base + 1, 200);
  endtask

  initial begin
    int base;
    // Reset hold with every client requesting
    op_a[7:0] = 8'd255;
    op_b[7:0] = 8'd255;
    req = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_start", mul_start, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_mul_a", mul_a, 0);
    check_eq("rst_mul_b", mul_b, 0);
    check_eq("rst_taints", {gnt_t, mul_start_t, mul_op_t, result_t, done_t}, 0);
    q.push_back(mk(0, 8'd255, 8'd255, '0, 1'b0, 1'b0));
    @(posedge clk); #2 rst = 1'b1;
    wait_gnt();
    req = '0;
    wait_done(1, 200);

    // Single job, then one that moves rr_ptr back to 0
    do_job(2, 8'd13, 8'd11, '0, 1'b0, 1'b0);
    do_job(3, 8'd200, 8'd255, '0, 1'b0, 1'b0);

    // Fairness with all requests held
    base = jobs_done;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i*WIDTH +: WIDTH] = 8'(40 + 37*i);
      op_b[i*WIDTH +: WIDTH] = 8'(201 - 23*i);
    end
    for (int j = 0; j < 5; j++)
      q.push_back(mk(j % 4, 8'(40 + 37*(j % 4)), 8'(201 - 23*(j % 4)), '0, 1'b0, 1'b0));
    req = 4'hF;
    wait_done(base + 5, 600);
    req = '0;

    // Taint: foreign req_t, then clean, then operand taint only
    do_job(1, 8'd6, 8'd7, 4'b1000, 1'b0, 1'b0);
    do_job(2, 8'd3, 8'd4, '0, 1'b0, 1'b0);
    do_job(3, 8'd10, 8'd12, '0, 1'b1, 1'b0);

    // Timeout, then a stray mul_done while idle
    hang = 1'b1;
    do_job(0, 8'd5, 8'd7, '0, 1'b0, 1'b1);
    hang = 1'b0;
    base = jobs_done;
    @(posedge clk); #2;
    inj_prod = 16'hBEEF;
    inj_done = 1'b1;
    @(posedge clk); #2;
    inj_done = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    check_eq("late_result", result, 0);
    check_eq("late_err", err, 1);
    check_eq("late_nodone", jobs_done, base);
    check_eq("late_gnt", gnt, 0);

    // Mid-job reset with rr_ptr away from 0
    do_job(1, 8'd9, 8'd9, '0, 1'b0, 1'b0);
    base = jobs_done;
    op_a[3*WIDTH +: WIDTH] = 8'd77;
    op_b[3*WIDTH +: WIDTH] = 8'd88;
    q.push_back(mk(3, 8'd77, 8'd88, '0, 1'b0, 1'b0));
    req[3] = 1'b1;
    wait_gnt();
    req = '0;
    repeat (5) begin @(posedge clk); #2; end
    rst = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    q.delete();
    check_eq("mrst_gnt", gnt, 0);
    check_eq("mrst_done", done, 0);
    check_eq("mrst_start", mul_start, 0);
    check_eq("mrst_result", result, 0);
    repeat (3) begin @(posedge clk); #2; end
    check_eq("mrst_nodone", jobs_done, base);
    op_a[7:0] = 8'd100;
    op_b[7:0] = 8'd3;
    q.push_back(mk(0, 8'd100, 8'd3, '0, 1'b0, 1'b0));
    req = 4'hF;
    wait_gnt();
    req = '0;
    wait_done(base + 1, 200);
    check_eq("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
